mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
//  Encoder for the R/I/J CPU's control decoder. It packs an operation kind and
//  its fields into a 32-bit MIPS word and writes that word into instruction memory.
//  Addresses are consecutive. The block builds programs/test images on-chip from
//  a host FSM or the bench; its opcode[31:26]/funct[5:0] values are exactly what
//  the decoder consumes as opa/func.
// PARAMETERS
//  ADDR_W  6   instruction-memory word-address width
//  DEPTH   64  words writable before FULL (DEPTH <= 2**ADDR_W)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  prog_clr    in   1       sync clear of write pointer/FULL; no effect while ENC/WR
//  req_valid   in   1       request present
//  req_ready   out  1       encoder can accept (IDLE only)
//  req_kind    in   5       operation code, table in pkg (0..25 legal)
//  req_rs      in   5       source reg
//  req_rt      in   5       target reg
//  req_rd      in   5       dest reg
//  req_shamt   in   5       shift amount
//  req_imm     in   16      immediate/offset
//  req_target  in   26      jump target (word index)
//  im_we       out  1       IM write strobe, 1 cycle
//  im_addr     out  ADDR_W  IM write address
//  im_wdata    out  32      encoded word
//  err_illegal out  1       1-cycle pulse: illegal kind rejected
//  full        out  1       DEPTH words written; level
//  wr_count    out  ADDR_W+1 words written since clear
// BEHAVIOUR
//  Reset values: all outputs 0, except req_ready=1; pointer=0; state IDLE.
//  Handshake: a request transfers on a clk edge with req_valid&req_ready. Fields latch on that edge.
//  FSM:
//   IDLE -> ENC on transfer.
//   ENC (1 cycle): im_wdata is registered at the end. Illegal kind -> IDLE, err_illegal=1 for 1 cycle, no write.
//   WR (1 cycle): im_we=1 with im_addr=ptr. Next: ptr++, wr_count++. Go to FULL if wr_count reaches DEPTH, else IDLE.
//   FULL: req_ready=0, full=1; only prog_clr or rst leave it (-> IDLE, ptr=0, count=0).
//  Latency: transfer at edge N -> im_we high during cycle N+2 (after edge N+2).
//   Max throughput is 1 word / 3 cycles.
//  im_wdata holds its last value outside WR. im_addr = ptr always.
//  prog_clr in IDLE/FULL takes effect the next edge; prog_clr together with req_valid in IDLE: clear wins, no transfer.
//  Encoding (op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] sh=[10:6] fn=[5:0]):
//   R (op=000000): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110,
//     NOR 100111, SLT 101010, SLLV 000100, SRLV 000110, SRAV 000111.
//     For these R ops sh=0.
//   SLL 000000, SRL 000010, SRA 000011: rs forced 0.
//   JR 001000: rt=rd=sh forced 0.
//   I (imm=[15:0]): ADDI 001000, ANDI 001100, ORI 001101, XORI 001110,
//     SLTI 001010, LW 100011, SW 101011, BEQ 000100, BNE 000101.
//     LUI 001111 has rs forced 0.
//   J (target=[25:0]): J 000010, JAL 000011.
//   Unused request fields are ignored, never OR'd in.
//  rst mid-operation: ENC/WR abort, no im_we, pointer/count return to 0.
//  No wrap-around: the pointer never exceeds DEPTH-1 because FULL blocks further requests.
// STRUCTURE
//  Package mips_isa_pkg holds:
//   - kind enum (ADD=0..JAL=25, order as listed above)
//   - OP_* and FN_* 6-bit constants, shared with TRANSLATE_CONTROL
//   - state typedef {IDLE, ENC, WR, FULL}
//  Sub-module mips_word_pack: purely combinational kind+fields -> {word, illegal}.
//  Top: FSM, field registers, pointer/count.
// TESTING
//  1 ADD rs=1 rt=2 rd=3 -> im_we at N+2, addr 0, wdata 32'h00221820.
//  2 ADDI rs=1 rt=2 imm=16'hFFFF then J target=26'h10 -> addr0 32'h2022FFFF, addr1 32'h08000010.
//  3 SLL rs=7(ignored) rt=2 rd=4 sh=3 -> 32'h000220C0. LUI rs=5 rt=1 imm=16'h1234 -> 32'h3C011234.
//  4 kind=27 -> err_illegal pulse cycle N+1, no im_we, wr_count unchanged, req_ready back to 1.
//  5 DEPTH=4: 4 writes -> full=1, req_ready=0, held valid ignored; prog_clr -> full=0, next write addr 0.
//  6 rst asserted in ENC -> no im_we ever for that request; all outputs at reset values next cycle.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder:
// request kinds, opcode/funct constants, encoder FSM states and word builders.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,
    K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLLV, K_SRLV, K_SRAV,
    K_SLL, K_SRL, K_SRA,
    K_JR,
    K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LW, K_SW, K_BEQ, K_BNE,
    K_LUI,
    K_J, K_JAL
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: turns a request kind plus its fields into one MIPS word,
// flagging kinds outside the table as illegal.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Each kind picks only the fields its format uses, so stray request bits never leak in.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind_e'(kind))
      K_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      K_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      K_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
      K_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
      K_XOR:  word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      K_NOR:  word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      K_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      K_SLLV: word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      K_SRLV: word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      K_SRAV: word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      K_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      K_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      K_SRA:  word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      K_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      K_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      K_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      K_XORI: word = i_word(OP_XORI, rs, rt, imm);
      K_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      K_LW:   word = i_word(OP_LW, rs, rt, imm);
      K_SW:   word = i_word(OP_SW, rs, rt, imm);
      K_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      K_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      K_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      K_J:    word = j_word(OP_J, target);
      K_JAL:  word = j_word(OP_JAL, target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction encoder: accepts one request at a time, packs it into a MIPS word
// and writes it to consecutive instruction-memory addresses until DEPTH words.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              err_illegal,
  output logic              full,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  state_e state, next_state;

  logic [4:0]        kind_q, rs_q, rt_q, rd_q, shamt_q;
  logic [15:0]       imm_q;
  logic [25:0]       target_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic              transfer, clear, last_word;

  mips_word_pack u_pack (
    .kind    (kind_q),
    .rs      (rs_q),
    .rt      (rt_q),
    .rd      (rd_q),
    .shamt   (shamt_q),
    .imm     (imm_q),
    .target  (target_q),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // The write strobe trails WR by one register stage; pointer and count advance as it drops.
  assign transfer  = req_valid && (state == IDLE) && !prog_clr;
  assign clear     = prog_clr && ((state == IDLE) || (state == FULL)) && !im_we;
  assign last_word = (count == LAST_COUNT);
  assign im_addr   = ptr;
  assign wr_count  = count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    full       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (transfer) next_state = ENC;
      end
      ENC:  next_state = packed_illegal ? IDLE : WR;
      WR:   next_state = last_word ? FULL : IDLE;
      FULL: begin
        full = 1'b1;
        if (clear) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      imm_q       <= '0;
      target_q    <= '0;
      im_we       <= 1'b0;
      im_wdata    <= '0;
      err_illegal <= 1'b0;
      ptr         <= '0;
      count       <= '0;
    end else begin
      im_we       <= 1'b0;
      err_illegal <= 1'b0;
      if (transfer) begin
        kind_q   <= req_kind;
        rs_q     <= req_rs;
        rt_q     <= req_rt;
        rd_q     <= req_rd;
        shamt_q  <= req_shamt;
        imm_q    <= req_imm;
        target_q <= req_target;
      end
      if (state == ENC) begin
        if (packed_illegal) err_illegal <= 1'b1;
        else                im_wdata    <= packed_word;
      end
      if (state == WR) im_we <= 1'b1;
      // The pointer stops at the last slot; FULL then blocks any further write.
      if (clear) begin
        ptr   <= '0;
        count <= '0;
      end else if (im_we) begin
        count <= count + 1'b1;
        if (!last_word) ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with DEPTH=4 so the FULL boundary is reachable.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, prog_clr, req_valid, req_ready;
  logic [4:0]        req_kind, req_rs, req_rt, req_rd, req_shamt;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              im_we, err_illegal, full;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   wr_count;

  int vectors     = 0;
  int miscompares = 0;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_clr    (prog_clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_shamt   (req_shamt),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .err_illegal (err_illegal),
    .full        (full),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] kind, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sh, input logic [15:0] imm,
                                input logic [25:0] tgt);
    req_kind   = kind;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_shamt  = sh;
    req_imm    = imm;
    req_target = tgt;
    req_valid  = 1'b1;
  endtask

  // Transfer at edge N, strobe after edge N+2, count advanced after edge N+3.
  task automatic write_word(input string tag, input logic [4:0] kind, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tgt,
                            input logic [31:0] exp_word, input logic [5:0] exp_addr,
                            input logic [6:0] exp_count);
    check_output({tag, " ready"}, 32'(req_ready), 32'd1);
    apply_stimulus(kind, rs, rt, rd, sh, imm, tgt);
    step();
    req_valid = 1'b0;
    check_output({tag, " busy"}, 32'(req_ready), 32'd0);
    step();
    check_output({tag, " we early"}, 32'(im_we), 32'd0);
    check_output({tag, " err"}, 32'(err_illegal), 32'd0);
    step();
    check_output({tag, " we"}, 32'(im_we), 32'd1);
    check_output({tag, " addr"}, 32'(im_addr), 32'(exp_addr));
    check_output({tag, " wdata"}, im_wdata, exp_word);
    step();
    check_output({tag, " we drop"}, 32'(im_we), 32'd0);
    check_output({tag, " count"}, 32'(wr_count), 32'(exp_count));
  endtask

  initial begin
    rst = 1'b1;
    prog_clr = 1'b0;
    apply_stimulus(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    req_valid = 1'b0;
    step();
    step();
    check_output("rst ready", 32'(req_ready), 32'd1);
    check_output("rst we", 32'(im_we), 32'd0);
    check_output("rst err", 32'(err_illegal), 32'd0);
    check_output("rst full", 32'(full), 32'd0);
    check_output("rst count", 32'(wr_count), 32'd0);
    check_output("rst addr", 32'(im_addr), 32'd0);
    check_output("rst wdata", im_wdata, 32'd0);
    rst = 1'b0;
    step();

    write_word("add", K_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h00221820, 6'd0, 7'd1);

    prog_clr = 1'b1;
    step();
    prog_clr = 1'b0;
    check_output("clr count", 32'(wr_count), 32'd0);
    check_output("clr addr", 32'(im_addr), 32'd0);

    write_word("addi", K_ADDI, 5'd1, 5'd2, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF,
               32'h2022FFFF, 6'd0, 7'd1);
    write_word("j", K_J, 5'd3, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h10,
               32'h08000010, 6'd1, 7'd2);

    apply_stimulus(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h5);
    step();
    req_valid = 1'b0;
    step();
    check_output("ill err", 32'(err_illegal), 32'd1);
    check_output("ill we", 32'(im_we), 32'd0);
    step();
    check_output("ill err drop", 32'(err_illegal), 32'd0);
    check_output("ill we after", 32'(im_we), 32'd0);
    check_output("ill ready", 32'(req_ready), 32'd1);
    check_output("ill count", 32'(wr_count), 32'd2);
    check_output("ill wdata hold", im_wdata, 32'h08000010);

    write_word("sll", K_SLL, 5'd7, 5'd2, 5'd4, 5'd3, 16'hABCD, 26'h1234567,
               32'h000220C0, 6'd2, 7'd3);
    write_word("lui", K_LUI, 5'd5, 5'd1, 5'd3, 5'd9, 16'h1234, 26'h3FFFFFF,
               32'h3C011234, 6'd3, 7'd4);

    check_output("full level", 32'(full), 32'd1);
    check_output("full ready", 32'(req_ready), 32'd0);
    apply_stimulus(K_ADD, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("full hold we", 32'(im_we), 32'd0);
      check_output("full hold", 32'(full), 32'd1);
    end
    req_valid = 1'b0;
    prog_clr  = 1'b1;
    step();
    prog_clr = 1'b0;
    check_output("unfull level", 32'(full), 32'd0);
    check_output("unfull count", 32'(wr_count), 32'd0);
    check_output("unfull ready", 32'(req_ready), 32'd1);

    prog_clr = 1'b1;
    apply_stimulus(K_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    step();
    prog_clr  = 1'b0;
    req_valid = 1'b0;
    check_output("clr wins ready", 32'(req_ready), 32'd1);
    check_output("clr wins count", 32'(wr_count), 32'd0);

    write_word("add2", K_ADD, 5'd4, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h3FFFFFF,
               32'h00853020, 6'd0, 7'd1);
    write_word("jr", K_JR, 5'd31, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF,
               32'h03E00008, 6'd1, 7'd2);

    apply_stimulus(K_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("mid rst ready", 32'(req_ready), 32'd1);
    check_output("mid rst we", 32'(im_we), 32'd0);
    check_output("mid rst err", 32'(err_illegal), 32'd0);
    check_output("mid rst full", 32'(full), 32'd0);
    check_output("mid rst count", 32'(wr_count), 32'd0);
    check_output("mid rst addr", 32'(im_addr), 32'd0);
    check_output("mid rst wdata", im_wdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("mid rst no we", 32'(im_we), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
